vga_text_writer: RTL and testbench
==================================

VGA_TEXT_WRITER -- requirements
Module: vga_text_writer

Interface
REQ-001 SHALL have parameter C_AXI_DATA_WIDTH, default 32, AXI-lite data width.
REQ-002 SHALL have parameter C_AXI_ADDR_WIDTH, default 15, AXI-lite byte address width.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk_i  input  1  sole clock; all logic on rising edge.
REQ-005 rstn_i  input  1  asynchronous active-low reset.
REQ-006 char_valid_i  input  1  character byte offered.
REQ-007 char_data_i  input  8  character byte (ASCII).
REQ-008 char_ready_o  output  1  block accepts a byte this cycle.
REQ-009 axil_waddr_o  output  C_AXI_ADDR_WIDTH  word-aligned write byte address.
REQ-010 axil_wdata_o  output  C_AXI_DATA_WIDTH  write data.
REQ-011 axil_wstrb_o  output  C_AXI_DATA_WIDTH/8  byte write strobes.
REQ-012 axil_wvalid_o  output  1  combined address+data valid.
REQ-013 axil_wready_i  input  1  responder accepts the write this cycle.
REQ-014 cursor_col_o  output  7  current column, 0-79.
REQ-015 cursor_row_o  output  5  current row, 0-29.
REQ-016 busy_o  output  1  high whenever state is not IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, WRITE, CLEAR; char_ready_o = 1 only in IDLE.
REQ-018 SHALL accept a byte when char_valid_i & char_ready_o are both high; an offered byte is not consumed while busy.
REQ-019 Printable byte 0x20-0x7E SHALL go to WRITE with axil_wvalid_o high the next cycle, addr = 15'h4000 + {tile[11:2],2'b00}, tile = row*80+col, wstrb = 1 << tile[1:0], byte lane tile[1:0] carrying the character, all other lanes 0.
REQ-020 While axil_wvalid_o is high, addr/data/strobe SHALL stay stable until the cycle axil_wready_i is high; in that cycle the write completes, the cursor advances and the FSM returns to IDLE.
REQ-021 Cursor advance: col+1; col 79 wraps to 0 with row+1; row 29 wraps to row 0 (no scroll).
REQ-022 0x0A (LF) SHALL set col=0, row+1 with the same row wrap; 0x0D (CR) SHALL set col=0; 0x08 (BS) SHALL set col-1, saturating at 0. None of these issue a write; the FSM stays in IDLE.
REQ-023 Any other byte, including bit7 set, SHALL be consumed with no write and no cursor change.
REQ-024 Every generated address SHALL lie in 15'h4000-15'h495C; tile range 0-2399.

Reset
REQ-025 While rstn_i is low, outputs SHALL be: char_ready_o=0, axil_wvalid_o=0, busy_o=0, addr/data/strb=0, cursor 0,0, state IDLE.
REQ-026 Reset asserted mid-WRITE or mid-CLEAR SHALL abort immediately with no further writes; char_ready_o SHALL be 1 in the first cycle after release.

Configuration
REQ-027 Macro VGA_TEXT_WRITER_CLEAR_EN defined: 0x0C (FF) SHALL enter CLEAR, issue 600 writes, each of 0x20202020 with wstrb 4'hF at 15'h4000 + 4k, k=0..599, one write per handshake, then set cursor 0,0 and return to IDLE.
REQ-028 Macro VGA_TEXT_WRITER_CLEAR_EN undefined: 0x0C SHALL be treated per REQ-023, and the CLEAR state and its word counter SHALL not exist.

Structure
REQ-029 Package vga_text_pkg SHALL hold N_COL=80, N_ROW=30, BUF_BASE=15'h4000, CLEAR_WORDS=600, the ASCII constants (LF, CR, BS, FF, SPACE) and the state enum type.
REQ-030 Cursor row/column counters with wrap and saturation SHALL live in sub-module vga_text_cursor; the FSM and write formatting stay in the top module.

Verification
REQ-031 Reset, send 'A' (0x41), wready held 1 -> one write: addr 15'h4000, wdata 32'h00000041, wstrb 4'b0001; cursor 0,1.
REQ-032 Send 'B' at col 3, row 0, wready held low 5 cycles then high -> wvalid stays high and stable 6 cycles, addr 15'h4000, wdata 32'h42000000, wstrb 4'b1000; char_ready_o stays low until completion.
REQ-033 Cursor 79,29, send 'Z' -> addr 15'h495C, wdata 32'h5A000000, wstrb 4'b1000; cursor wraps to 0,0.
REQ-034 Cursor 5,2, send CR, then LF, then BS -> no writes; cursor 0,2, then 0,3, then 0,3.
REQ-035 With VGA_TEXT_WRITER_CLEAR_EN, send 0x0C with wready=1 -> exactly 600 writes of 32'h20202020, last at 15'h495C; cursor 0,0. Without the macro -> no writes.
REQ-036 Assert rstn_i during the 10th clear write -> wvalid drops the same cycle; no writes after release; char_ready_o=1 the first cycle after release.

Source files
------------

// File: rtl/vga_text_pkg.sv
// Shared constants and FSM state type for the VGA text writer.
// VGA_TEXT_WRITER_CLEAR_EN adds the CLEAR state used by the form-feed screen clear.
package vga_text_pkg;

  localparam int          N_COL       = 80;
  localparam int          N_ROW       = 30;
  localparam logic [14:0] BUF_BASE    = 15'h4000;
  localparam int          CLEAR_WORDS = 600;

  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_FF    = 8'h0C;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1
`ifdef VGA_TEXT_WRITER_CLEAR_EN
    ,CLEAR = 2'd2
`endif
  } state_e;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

endpackage

// File: rtl/vga_text_cursor.sv
// Text cursor position: column/row counters with line wrap, screen wrap,
// newline, carriage return, saturating backspace and home.
module vga_text_cursor
  import vga_text_pkg::*;
(
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       adv_i,
  input  logic       newline_i,
  input  logic       cr_i,
  input  logic       bs_i,
  input  logic       home_i,
  output logic [6:0] col_o,
  output logic [4:0] row_o
);

  logic [6:0] col_q, col_d;
  logic [4:0] row_q, row_d;
  logic [4:0] row_inc;

  always_comb begin
    row_inc = (row_q == 5'(N_ROW - 1)) ? 5'd0 : row_q + 5'd1;
    col_d   = col_q;
    row_d   = row_q;
    if (home_i) begin
      col_d = '0;
      row_d = '0;
    end else if (adv_i) begin
      if (col_q == 7'(N_COL - 1)) begin
        col_d = '0;
        row_d = row_inc;
      end else begin
        col_d = col_q + 7'd1;
      end
    end else if (newline_i) begin
      col_d = '0;
      row_d = row_inc;
    end else if (cr_i) begin
      col_d = '0;
    end else if (bs_i && (col_q != 7'd0)) begin
      col_d = col_q - 7'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col_o = col_q;
  assign row_o = row_q;

endmodule

// File: rtl/vga_text_writer.sv
// Turns a stream of ASCII bytes into AXI-lite byte writes into an 80x30 text buffer.
// VGA_TEXT_WRITER_CLEAR_EN enables form-feed (0x0C) clearing of the whole buffer.
module vga_text_writer
  import vga_text_pkg::*;
#(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 15
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          char_valid_i,
  input  logic [7:0]                    char_data_i,
  output logic                          char_ready_o,
  output logic [C_AXI_ADDR_WIDTH-1:0]   axil_waddr_o,
  output logic [C_AXI_DATA_WIDTH-1:0]   axil_wdata_o,
  output logic [C_AXI_DATA_WIDTH/8-1:0] axil_wstrb_o,
  output logic                          axil_wvalid_o,
  input  logic                          axil_wready_i,
  output logic [6:0]                    cursor_col_o,
  output logic [4:0]                    cursor_row_o,
  output logic                          busy_o
);

  localparam int AW     = C_AXI_ADDR_WIDTH;
  localparam int DW     = C_AXI_DATA_WIDTH;
  localparam int STRB_W = DW / 8;

  state_e            state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     data_q, data_d;
  logic [STRB_W-1:0] strb_q, strb_d;
`ifdef VGA_TEXT_WRITER_CLEAR_EN
  logic [9:0]        clr_cnt_q, clr_cnt_d;
`endif

  logic       cur_adv, cur_nl, cur_cr, cur_bs, cur_home;
  logic [6:0] cur_col;
  logic [4:0] cur_row;
  logic [11:0] tile;

  vga_text_cursor u_cursor (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .adv_i     (cur_adv),
    .newline_i (cur_nl),
    .cr_i      (cur_cr),
    .bs_i      (cur_bs),
    .home_i    (cur_home),
    .col_o     (cur_col),
    .row_o     (cur_row)
  );

  assign tile = 12'(cur_row) * 12'(N_COL) + 12'(cur_col);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    strb_d   = strb_q;
    cur_adv  = 1'b0;
    cur_nl   = 1'b0;
    cur_cr   = 1'b0;
    cur_bs   = 1'b0;
    cur_home = 1'b0;
`ifdef VGA_TEXT_WRITER_CLEAR_EN
    clr_cnt_d = clr_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (char_valid_i) begin
          if (is_printable(char_data_i)) begin
            // Word-aligned address; the column's low two tile bits pick the byte lane.
            state_d = WRITE;
            addr_d  = AW'(BUF_BASE) + AW'({tile[11:2], 2'b00});
            data_d  = '0;
            data_d[8*int'(tile[1:0]) +: 8] = char_data_i;
            strb_d  = STRB_W'(1) << tile[1:0];
          end else if (char_data_i == ASCII_LF) begin
            cur_nl = 1'b1;
          end else if (char_data_i == ASCII_CR) begin
            cur_cr = 1'b1;
          end else if (char_data_i == ASCII_BS) begin
            cur_bs = 1'b1;
`ifdef VGA_TEXT_WRITER_CLEAR_EN
          end else if (char_data_i == ASCII_FF) begin
            state_d   = CLEAR;
            addr_d    = AW'(BUF_BASE);
            data_d    = {STRB_W{ASCII_SPACE}};
            strb_d    = '1;
            clr_cnt_d = '0;
`endif
          end
        end
      end
      WRITE: begin
        if (axil_wready_i) begin
          cur_adv = 1'b1;
          state_d = IDLE;
        end
      end
`ifdef VGA_TEXT_WRITER_CLEAR_EN
      CLEAR: begin
        if (axil_wready_i) begin
          if (clr_cnt_q == 10'(CLEAR_WORDS - 1)) begin
            cur_home = 1'b1;
            state_d  = IDLE;
          end else begin
            clr_cnt_d = clr_cnt_q + 10'd1;
            addr_d    = addr_q + AW'(4);
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      strb_q    <= '0;
`ifdef VGA_TEXT_WRITER_CLEAR_EN
      clr_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      strb_q    <= strb_d;
`ifdef VGA_TEXT_WRITER_CLEAR_EN
      clr_cnt_q <= clr_cnt_d;
`endif
    end
  end

  // Ready is masked by reset so it reads low while rstn_i is held.
  assign char_ready_o  = rstn_i && (state_q == IDLE);
  assign busy_o        = (state_q != IDLE);
  assign axil_wvalid_o = (state_q != IDLE);
  assign axil_waddr_o  = addr_q;
  assign axil_wdata_o  = data_q;
  assign axil_wstrb_o  = strb_q;
  assign cursor_col_o  = cur_col;
  assign cursor_row_o  = cur_row;

endmodule

// File: tb/tb_vga_text_writer.sv
// Directed bench for vga_text_writer: vector table plus hand-written multi-cycle sequences.
// Clear-related sequences follow VGA_TEXT_WRITER_CLEAR_EN.
module tb_vga_text_writer;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        char_valid = 1'b0;
  logic [7:0]  char_data = 8'h00;
  logic        char_ready;
  logic [14:0] waddr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready = 1'b1;
  logic [6:0]  col;
  logic [4:0]  row;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  int          wr_total = 0;
  int          clr_bad = 0;
  int          clr_base = 0;
  logic        clr_mode = 1'b0;
  logic [14:0] last_addr = '0;
  logic [31:0] last_data = '0;
  logic [3:0]  last_strb = '0;

  vga_text_writer #(
    .C_AXI_DATA_WIDTH (32),
    .C_AXI_ADDR_WIDTH (15)
  ) dut (
    .clk_i         (clk),
    .rstn_i        (rstn),
    .char_valid_i  (char_valid),
    .char_data_i   (char_data),
    .char_ready_o  (char_ready),
    .axil_waddr_o  (waddr),
    .axil_wdata_o  (wdata),
    .axil_wstrb_o  (wstrb),
    .axil_wvalid_o (wvalid),
    .axil_wready_i (wready),
    .cursor_col_o  (col),
    .cursor_row_o  (row),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rstn && wvalid && wready) begin
      wr_total  <= wr_total + 1;
      last_addr <= waddr;
      last_data <= wdata;
      last_strb <= wstrb;
      if (clr_mode && ((wdata != 32'h20202020) || (wstrb != 4'hF) ||
                       (waddr != 15'h4000 + 15'((wr_total - clr_base) * 4))))
        clr_bad <= clr_bad + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    char_valid = 1'b0;
    wready = 1'b1;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  // Offer one byte at a negedge, then wait for the block to go idle again.
  task automatic send(input logic [7:0] ch);
    int n;
    n = 0;
    while (!char_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!char_ready) chk("ready_timeout", 32'(char_ready), 32'd1);
    char_valid = 1'b1;
    char_data  = ch;
    @(negedge clk);
    char_valid = 1'b0;
    n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("busy_timeout", 32'(busy), 32'd0);
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0]  ch;
    int          nwr;
    logic [14:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [6:0]  col;
    logic [4:0]  row;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int w0;
    int n;

    vecs[0]  = '{8'h41, 1, 15'h4000, 32'h00000041, 4'h1, 7'd1, 5'd0};
    vecs[1]  = '{8'h62, 1, 15'h4000, 32'h00006200, 4'h2, 7'd2, 5'd0};
    vecs[2]  = '{8'h63, 1, 15'h4000, 32'h00630000, 4'h4, 7'd3, 5'd0};
    vecs[3]  = '{8'h08, 0, 15'h0000, 32'h00000000, 4'h0, 7'd2, 5'd0};
    vecs[4]  = '{8'h80, 0, 15'h0000, 32'h00000000, 4'h0, 7'd2, 5'd0};
    vecs[5]  = '{8'h0A, 0, 15'h0000, 32'h00000000, 4'h0, 7'd0, 5'd1};
    vecs[6]  = '{8'h7E, 1, 15'h4050, 32'h0000007E, 4'h1, 7'd1, 5'd1};
    vecs[7]  = '{8'h7F, 0, 15'h0000, 32'h00000000, 4'h0, 7'd1, 5'd1};
    vecs[8]  = '{8'h1F, 0, 15'h0000, 32'h00000000, 4'h0, 7'd1, 5'd1};
    vecs[9]  = '{8'h20, 1, 15'h4050, 32'h00002000, 4'h2, 7'd2, 5'd1};
    vecs[10] = '{8'h0D, 0, 15'h0000, 32'h00000000, 4'h0, 7'd0, 5'd1};
    vecs[11] = '{8'h08, 0, 15'h0000, 32'h00000000, 4'h0, 7'd0, 5'd1};
    vecs[12] = '{8'hFF, 0, 15'h0000, 32'h00000000, 4'h0, 7'd0, 5'd1};

    // Outputs while held in reset
    #12;
    chk("rst_ready",  32'(char_ready), 32'd0);
    chk("rst_wvalid", 32'(wvalid), 32'd0);
    chk("rst_busy",   32'(busy), 32'd0);
    chk("rst_addr",   32'(waddr), 32'd0);
    chk("rst_data",   wdata, 32'd0);
    chk("rst_strb",   32'(wstrb), 32'd0);
    chk("rst_col",    32'(col), 32'd0);
    chk("rst_row",    32'(row), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(char_ready), 32'd1);

    for (int i = 0; i < 13; i++) begin
      w0 = wr_total;
      send(vecs[i].ch);
      chk($sformatf("vec%0d_nwr", i), 32'(wr_total - w0), 32'(vecs[i].nwr));
      if (vecs[i].nwr != 0) begin
        chk($sformatf("vec%0d_addr", i), 32'(last_addr), 32'(vecs[i].addr));
        chk($sformatf("vec%0d_data", i), last_data, vecs[i].data);
        chk($sformatf("vec%0d_strb", i), 32'(last_strb), 32'(vecs[i].strb));
      end
      chk($sformatf("vec%0d_col", i), 32'(col), 32'(vecs[i].col));
      chk($sformatf("vec%0d_row", i), 32'(row), 32'(vecs[i].row));
    end

    // 'B' at column 3 with a stalled responder
    do_reset();
    send(8'h30); send(8'h31); send(8'h32);
    w0 = wr_total;
    wready = 1'b0;
    char_valid = 1'b1;
    char_data = 8'h42;
    @(negedge clk);
    char_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("stall%0d_wvalid", i), 32'(wvalid), 32'd1);
      chk($sformatf("stall%0d_addr", i), 32'(waddr), 32'h4000);
      chk($sformatf("stall%0d_data", i), wdata, 32'h42000000);
      chk($sformatf("stall%0d_strb", i), 32'(wstrb), 32'h8);
      chk($sformatf("stall%0d_ready", i), 32'(char_ready), 32'd0);
      if (i == 5) wready = 1'b1;
      @(negedge clk);
    end
    chk("stall_done_wvalid", 32'(wvalid), 32'd0);
    chk("stall_done_ready", 32'(char_ready), 32'd1);
    chk("stall_nwr", 32'(wr_total - w0), 32'd1);
    chk("stall_col", 32'(col), 32'd4);

    // Last cell of the screen, then wrap to home
    do_reset();
    for (int i = 0; i < 29; i++) send(8'h0A);
    for (int i = 0; i < 79; i++) send(8'h61);
    chk("corner_pre_col", 32'(col), 32'd79);
    chk("corner_pre_row", 32'(row), 32'd29);
    w0 = wr_total;
    send(8'h5A);
    chk("corner_nwr",  32'(wr_total - w0), 32'd1);
    chk("corner_addr", 32'(last_addr), 32'h495C);
    chk("corner_data", last_data, 32'h5A000000);
    chk("corner_strb", 32'(last_strb), 32'h8);
    chk("corner_col",  32'(col), 32'd0);
    chk("corner_row",  32'(row), 32'd0);

    // Cursor 5,2 then CR, LF, BS
    do_reset();
    send(8'h0A); send(8'h0A);
    for (int i = 0; i < 5; i++) send(8'h2E);
    w0 = wr_total;
    send(8'h0D);
    chk("cr_col", 32'(col), 32'd0);
    chk("cr_row", 32'(row), 32'd2);
    send(8'h0A);
    chk("lf_col", 32'(col), 32'd0);
    chk("lf_row", 32'(row), 32'd3);
    send(8'h08);
    chk("bs_col", 32'(col), 32'd0);
    chk("bs_row", 32'(row), 32'd3);
    chk("ctrl_nwr", 32'(wr_total - w0), 32'd0);

    // Form feed
    do_reset();
    send(8'h71); send(8'h72);
    w0 = wr_total;
    clr_base = wr_total;
    clr_mode = 1'b1;
    send(8'h0C);
    clr_mode = 1'b0;
`ifdef VGA_TEXT_WRITER_CLEAR_EN
    chk("clear_nwr",  32'(wr_total - w0), 32'd600);
    chk("clear_bad",  32'(clr_bad), 32'd0);
    chk("clear_last_addr", 32'(last_addr), 32'h495C);
    chk("clear_last_data", last_data, 32'h20202020);
    chk("clear_col",  32'(col), 32'd0);
    chk("clear_row",  32'(row), 32'd0);
`else
    chk("ff_nwr", 32'(wr_total - w0), 32'd0);
    chk("ff_col", 32'(col), 32'd2);
    chk("ff_row", 32'(row), 32'd0);
`endif

    // Reset while a character write is stalled
    do_reset();
    wready = 1'b0;
    char_valid = 1'b1;
    char_data = 8'h41;
    @(negedge clk);
    char_valid = 1'b0;
    chk("abw_wvalid_pre", 32'(wvalid), 32'd1);
    @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    chk("abw_wvalid", 32'(wvalid), 32'd0);
    chk("abw_ready",  32'(char_ready), 32'd0);
    chk("abw_busy",   32'(busy), 32'd0);
    wready = 1'b1;
    @(negedge clk);
    rstn = 1'b1;
    w0 = wr_total;
    #1;
    chk("abw_ready_release", 32'(char_ready), 32'd1);
    repeat (10) @(negedge clk);
    chk("abw_nwr", 32'(wr_total - w0), 32'd0);

`ifdef VGA_TEXT_WRITER_CLEAR_EN
    // Reset during the 10th clear write
    do_reset();
    send(8'h71);
    w0 = wr_total;
    char_valid = 1'b1;
    char_data = 8'h0C;
    @(negedge clk);
    char_valid = 1'b0;
    n = 0;
    while ((wr_total - w0) < 9 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("abc_nwr_before", 32'(wr_total - w0), 32'd9);
    chk("abc_wvalid_pre", 32'(wvalid), 32'd1);
    chk("abc_addr_pre",   32'(waddr), 32'h4024);
    rstn = 1'b0;
    #1;
    chk("abc_wvalid", 32'(wvalid), 32'd0);
    chk("abc_addr",   32'(waddr), 32'd0);
    chk("abc_col",    32'(col), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    w0 = wr_total;
    #1;
    chk("abc_ready_release", 32'(char_ready), 32'd1);
    repeat (20) @(negedge clk);
    chk("abc_nwr_after", 32'(wr_total - w0), 32'd0);
    chk("abc_wvalid_after", 32'(wvalid), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
